// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: instruction memory address/data plus the
// valid/ready instruction handshake towards the decoder.
interface instr_fetch_if #(
  parameter int N  = 16,
  parameter int AW = 10
);
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_data;
  logic          instr_valid;
  logic [N-1:0]  instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;

  modport master (
    output mem_addr,
    input  mem_data,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_addr,
    output mem_data,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, synchronous-memory request tracking and a
// 2-entry {word, pc} output FIFO. Define FETCH_PERF_EN for fetch/stall counters.
module instr_fetch #(
  parameter int            N        = 16,
  parameter int            AW       = 10,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          branch_valid,
  input  logic [AW-1:0] branch_target,
  input  logic          halt,
`ifdef FETCH_PERF_EN
  output logic [15:0]   fetch_count,
  output logic [15:0]   stall_count,
`endif
  instr_fetch_if.master bus
);

  logic [AW-1:0]         pc_q, pc_d;
  logic                  req_q, req_d;
  logic [AW-1:0]         req_pc_q, req_pc_d;
  logic [1:0]            count_q, count_d;
  logic [1:0][N-1:0]     word_q, word_d;
  logic [1:0][AW-1:0]    slot_pc_q, slot_pc_d;

  logic                  valid;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  stall;
  logic [2:0]            occupancy_next;
  logic [1:0]            count_after_pop;

  assign valid = (count_q != 2'd0);
  assign pop   = valid & bus.instr_ready;
  assign stall = valid & ~bus.instr_ready;
  assign push  = req_q & ~branch_valid;

  // Issue only when the word it produces is sure to find a free FIFO slot.
  assign occupancy_next = {1'b0, count_q} + {2'b00, req_q} - {2'b00, pop};
  assign issue          = ~halt & ~branch_valid & (occupancy_next < 3'd2);

  always_comb begin
    pc_d     = pc_q;
    req_d    = 1'b0;
    req_pc_d = req_pc_q;
    if (branch_valid) begin
      pc_d = branch_target;
    end else if (issue) begin
      req_d    = 1'b1;
      req_pc_d = pc_q;
      pc_d     = pc_q + AW'(1);
    end
  end

  // Head is always slot 0; a pop shifts slot 1 down before any push lands.
  always_comb begin
    word_d          = word_q;
    slot_pc_d       = slot_pc_q;
    count_after_pop = count_q - {1'b0, pop};
    count_d         = count_after_pop + {1'b0, push};
    if (pop) begin
      word_d[0]    = word_q[1];
      slot_pc_d[0] = slot_pc_q[1];
    end
    if (push) begin
      if (count_after_pop == 2'd0) begin
        word_d[0]    = bus.mem_data;
        slot_pc_d[0] = req_pc_q;
      end else begin
        word_d[1]    = bus.mem_data;
        slot_pc_d[1] = req_pc_q;
      end
    end
    if (branch_valid) begin
      count_d = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      req_pc_q  <= '0;
      count_q   <= 2'd0;
      word_q    <= '0;
      slot_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      req_q     <= req_d;
      req_pc_q  <= req_pc_d;
      count_q   <= count_d;
      word_q    <= word_d;
      slot_pc_q <= slot_pc_d;
    end
  end

  assign bus.mem_addr    = pc_q;
  assign bus.instr_valid = valid;
  assign bus.instr       = word_q[0];
  assign bus.instr_pc    = slot_pc_q[0];

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q + {15'd0, pop};
    stall_count_d = stall_count_q + {15'd0, stall};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= 16'd0;
      stall_count_q <= 16'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, branch, halt,
// address wrap (second instance at RESET_PC=1022), async reset and counters.
module tb_instr_fetch;
  localparam int N  = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          branch_valid = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic          halt = 1'b0;
  logic          tie0 = 1'b0;
  logic [AW-1:0] tie0_addr = '0;

  int checks = 0;
  int errors = 0;

  instr_fetch_if #(.N(N), .AW(AW)) bus0 ();
  instr_fetch_if #(.N(N), .AW(AW)) bus1 ();

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count0, stall_count0, fetch_count1, stall_count1;
`endif

  instr_fetch #(.N(N), .AW(AW), .RESET_PC(10'd0)) dut0 (
    .clk           (clk),
    .rst           (rst),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .halt          (halt),
`ifdef FETCH_PERF_EN
    .fetch_count   (fetch_count0),
    .stall_count   (stall_count0),
`endif
    .bus           (bus0)
  );

  instr_fetch #(.N(N), .AW(AW), .RESET_PC(10'd1022)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .branch_valid  (tie0),
    .branch_target (tie0_addr),
    .halt          (tie0),
`ifdef FETCH_PERF_EN
    .fetch_count   (fetch_count1),
    .stall_count   (stall_count1),
`endif
    .bus           (bus1)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] word_at(input logic [AW-1:0] a);
    return 16'hA000 + {6'd0, a};
  endfunction

  // Synchronous memory models: address in cycle t, data in cycle t+1.
  always @(posedge clk) bus0.mem_data <= word_at(bus0.mem_addr);
  always @(posedge clk) bus1.mem_data <= word_at(bus1.mem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic br,
                               input logic [AW-1:0] tgt, input logic hlt);
    bus0.instr_ready = ready;
    branch_valid     = br;
    branch_target    = tgt;
    halt             = hlt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkPresented(input string tag, input logic [AW-1:0] pc);
    checkOutput({tag, "_valid"}, 32'(bus0.instr_valid), 32'd1);
    checkOutput({tag, "_pc"}, 32'(bus0.instr_pc), 32'(pc));
    checkOutput({tag, "_instr"}, 32'(bus0.instr), 32'(word_at(pc)));
  endtask

  initial begin
    logic [AW-1:0] wrap_pc;
    bus0.instr_ready = 1'b1;
    bus1.instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 32'(bus0.instr_valid), 32'd0);
    checkOutput("rst_instr", 32'(bus0.instr), 32'd0);
    checkOutput("rst_pc", 32'(bus0.instr_pc), 32'd0);
    checkOutput("rst_addr1", 32'(bus1.mem_addr), 32'd1022);
    rst = 1'b0;

    // cycle 0
    checkOutput("c0_addr", 32'(bus0.mem_addr), 32'd0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkOutput("c1_valid", 32'(bus0.instr_valid), 32'd0);
    checkOutput("c1_addr", 32'(bus0.mem_addr), 32'd1);

    // cycles 2..5: streaming; dut1 wraps 1022, 1023, 0, 1
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      checkPresented("stream", AW'(k));
      wrap_pc = AW'(1022 + k);
      checkOutput("wrap_valid", 32'(bus1.instr_valid), 32'd1);
      checkOutput("wrap_pc", 32'(bus1.instr_pc), 32'(wrap_pc));
      checkOutput("wrap_instr", 32'(bus1.instr), 32'(word_at(wrap_pc)));
    end

    // cycles 5..9: ready low with pc 3 at the head
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkPresented("bp_hold", 10'd3);
      checkOutput("bp_addr", 32'(bus0.mem_addr), 32'd5);
    end

    // cycles 10..13: resume; 4, 5, 6, 7 follow back-to-back
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      checkPresented("bp_resume", AW'(4 + k));
    end

    // cycle 14: pc 7 accepted together with a branch to 0x200
    applyStimulus(1'b1, 1'b1, 10'h200, 1'b0);
    checkOutput("br_bubble1", 32'(bus0.instr_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkOutput("br_bubble2", 32'(bus0.instr_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkPresented("br_target", 10'h200);

    // cycles 17..20: halt
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    checkPresented("halt_drain", 10'h201);
    checkOutput("halt_addr0", 32'(bus0.mem_addr), 32'h202);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b1);
      checkOutput("halt_valid", 32'(bus0.instr_valid), 32'd0);
      checkOutput("halt_addr", 32'(bus0.mem_addr), 32'h202);
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkOutput("unhalt_valid", 32'(bus0.instr_valid), 32'd0);
    checkOutput("unhalt_addr", 32'(bus0.mem_addr), 32'h203);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkPresented("unhalt_first", 10'h202);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkPresented("unhalt_next", 10'h203);

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(bus0.instr_valid), 32'd0);
    checkOutput("arst_instr", 32'(bus0.instr), 32'd0);
    checkOutput("arst_pc", 32'(bus0.instr_pc), 32'd0);
    checkOutput("arst_addr", 32'(bus0.mem_addr), 32'd0);
`ifdef FETCH_PERF_EN
    checkOutput("arst_fetch", 32'(fetch_count0), 32'd0);
    checkOutput("arst_stall", 32'(stall_count0), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // 10 deliveries (pc 0..9) with 3 stall cycles on pc 5
    repeat (7) applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkPresented("perf_pre", 10'd5);
    repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkPresented("perf_stall", 10'd5);
    repeat (5) applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkPresented("perf_post", 10'd10);
`ifdef FETCH_PERF_EN
    checkOutput("perf_fetch", 32'(fetch_count0), 32'd10);
    checkOutput("perf_stall", 32'(stall_count0), 32'd3);
    #2 rst = 1'b1;
    #1;
    checkOutput("perf_clr_fetch", 32'(fetch_count0), 32'd0);
    checkOutput("perf_clr_stall", 32'(stall_count0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch-side initiator for the synchronous instruction memory: owns the program counter, drives the memory address every cycle and captures the returned word one cycle later. Delivers instructions with their addresses to the decoder over a valid/ready handshake. Handles branch redirects, halts and 10-bit address wrap. Sits between the instruction memory and the control unit of the Pocket Calculator Processor.

## Interface
- `N`, 16, instruction word width
- `AW`, 10, instruction address width; memory depth is 2**AW
- `RESET_PC`, 0, first fetch address after reset
- `clk` in 1, system clock, all state on rising edge
- `rst` in 1, asynchronous active-high reset
- `mem_addr` out AW, address to instruction memory, equals `pc_q`
- `mem_data` in N, memory read data; the word for the address driven in cycle t is valid in cycle t+1
- `branch_valid` in 1, redirect request this cycle
- `branch_target` in AW, redirect address
- `halt` in 1, stop issuing new fetches while high
- `instr_valid` out 1, `instr`/`instr_pc` hold a valid instruction
- `instr` out N, instruction word
- `instr_pc` out AW, address the instruction was fetched from
- `instr_ready` in 1, decoder accepts the instruction this cycle
- `fetch_count` out 16, only with `FETCH_PERF_EN`
- `stall_count` out 16, only with `FETCH_PERF_EN`

## Operation
- State: `pc_q` (next address to issue), `req_q` (1 = request issued last cycle), `req_pc_q` (its address), 2-entry output FIFO of {word, pc}.
- Reset values: `pc_q`=RESET_PC, `req_q`=0, `req_pc_q`=0, FIFO empty, `instr_valid`=0, `instr`=0, `instr_pc`=0, counters 0.
- `mem_addr` = `pc_q` always; the memory reads every cycle, and only cycles marked by `req_q` are captured.
- pop = `instr_valid & instr_ready`; removes the FIFO head.
- issue when `!halt & !branch_valid & (occupancy + req_q - pop) < 2`: `req_q`<=1, `req_pc_q`<=`pc_q`, `pc_q`<=`pc_q`+1 mod 2**AW (1023 -> 0). Otherwise `req_q`<=0 and `pc_q` holds.
- capture: if `req_q`, push {`mem_data`, `req_pc_q`}; the issue rule guarantees space. Push and pop in the same cycle are legal.
- branch (`branch_valid`=1) has priority over everything. It flushes the FIFO, discards the in-flight word, sets `req_q`<=0 and `pc_q`<=`branch_target`. A pop in the same cycle completes normally and the popped word counts as delivered. No word fetched before the branch is ever presented after it.
- `halt`: no new issue. An in-flight word is still captured. FIFO contents stay presented until popped. `pc_q` is frozen.
- Outputs `instr`/`instr_pc` come from the FIFO head and are stable while `instr_valid & !instr_ready`.

## Timing
- First fetch: `rst` falls before edge E0, so `mem_addr`=RESET_PC in cycle 0, `mem_data` is valid in cycle 1, and `instr_valid`=1 in cycle 2.
- Load-to-use latency is 2 cycles from issue to `instr_valid`.
- Throughput is 1 instruction/cycle while `instr_ready`=1 and no branch or halt.
- Branch in cycle t: `instr_valid`=0 in t+1 and t+2; in t+3 `instr_valid`=1 with `instr_pc`=target. The penalty is 2 bubbles.
- Backpressure: with `instr_ready` low, at most 2 words are buffered and issue stops. When ready rises, delivery restarts with no loss or duplication.
- `rst` mid-operation: all state returns to reset values immediately (asynchronously) and the in-flight word is dropped.

## Configuration
- `FETCH_PERF_EN` defined: adds `fetch_count` and `stall_count`.
  - `fetch_count` increments on every pop.
  - `stall_count` increments on every cycle with `instr_valid & !instr_ready`.
  - Both are 16-bit, wrap at 65535 -> 0, and are cleared by `rst`.
- `FETCH_PERF_EN` undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Memory holds word = 0xA000+addr, `instr_ready`=1, release reset -> `instr_valid` rises in cycle 2, then (pc,instr) = (0,0xA000), (1,0xA001), (2,0xA002) on consecutive cycles.
- Hold `instr_ready`=0 for 5 cycles at pc 3 -> pc 3 is held stable, `mem_addr` stops at 5. After release, 3, 4, 5, 6 are delivered with no gap or duplicate.
- `branch_valid` with target 0x200 while pc 7 is presented and accepted -> 2 bubbles, then pc 0x200 / 0xA200. Words 8 and 9 are never presented.
- Start at `RESET_PC`=1022 -> pc sequence 1022, 1023, 0, 1 with matching words.
- `halt` high for 4 cycles -> at most the 2 outstanding words are delivered and `mem_addr` is frozen. When halt drops, the sequence resumes at the next pc.
- With `FETCH_PERF_EN`: 10 deliveries plus 3 stall cycles -> `fetch_count`=10, `stall_count`=3. Asserting `rst` clears both to 0.
